// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-back
// controller of the RV32I_M core.
//   XLEN     - integer data width
//   INDEX    - register index width (2**INDEX architectural registers)
//   wb_src_e - which path produced the registered write (none / ALU / M-unit)
//   wb_req_t - one write-back request: destination index plus data
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int INDEX = 5;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MD
  } wb_src_e;

  typedef struct packed {
    logic [INDEX-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundles the write-back side of the core.
//   ALU_VALID/ALU_RD/ALU_DATA        single-cycle write-back request
//   MD_VALID/MD_READY/MD_RD/MD_DATA  M-unit result handshake
//   ISSUE_MD/ISSUE_RD                M instruction issued this cycle
//   RS1/RS2/RD_CHK, STALL            hazard query from the issue stage
//   WE3/A3/WD3                       register-file write port
// modport master: core / register-file side; modport slave: the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int INDEX = regfile_pkg::INDEX
);
  logic             ALU_VALID;
  logic [INDEX-1:0] ALU_RD;
  logic [XLEN-1:0]  ALU_DATA;
  logic             MD_VALID;
  logic             MD_READY;
  logic [INDEX-1:0] MD_RD;
  logic [XLEN-1:0]  MD_DATA;
  logic             ISSUE_MD;
  logic [INDEX-1:0] ISSUE_RD;
  logic [INDEX-1:0] RS1;
  logic [INDEX-1:0] RS2;
  logic [INDEX-1:0] RD_CHK;
  logic             STALL;
  logic             WE3;
  logic [INDEX-1:0] A3;
  logic [XLEN-1:0]  WD3;

  modport master (
    output ALU_VALID, ALU_RD, ALU_DATA,
    output MD_VALID, MD_RD, MD_DATA,
    output ISSUE_MD, ISSUE_RD, RS1, RS2, RD_CHK,
    input  MD_READY, STALL, WE3, A3, WD3
  );

  modport slave (
    input  ALU_VALID, ALU_RD, ALU_DATA,
    input  MD_VALID, MD_RD, MD_DATA,
    input  ISSUE_MD, ISSUE_RD, RS1, RS2, RD_CHK,
    output MD_READY, STALL, WE3, A3, WD3
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO holding M-unit results until the shared
// register-file write port is free.
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push, din  write an entry (ignored when full)
//   pop, dout  dout is the head entry; pop removes it (ignored when empty)
//   full/empty occupancy flags derived from the entry count
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// the ALU/load write-back path and buffered M-unit results, and tracks which
// registers still await an M-unit result so issue can stall on hazards.
//   CLK, RST  clock, synchronous active-high reset
//   bus       regfile_wb_arbiter_if.slave (write-back, M handshake, hazards)
//   ERR       sticky protocol-error flag, present only when
//             REGFILE_WB_CHECK_EN is defined
// Priority: ALU (rd!=0) > FIFO head. A head with rd==0 is popped and dropped.
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int INDEX    = regfile_pkg::INDEX,
  parameter int MD_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_wb_arbiter_if.slave   bus
`ifdef REGFILE_WB_CHECK_EN
  ,
  output logic                  ERR
`endif
);
  localparam int NREG = 1 << INDEX;
  localparam int RW   = INDEX + XLEN;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [RW-1:0]    head;
  logic [INDEX-1:0] head_rd;
  logic [XLEN-1:0]  head_data;
  logic             md_full;
  logic             md_empty;
  logic             md_push;
  logic             md_pop;
  logic             alu_grant;
  logic             md_grant;
  logic             issue_set;

  logic             we_p1;
  logic [INDEX-1:0] a3_p1;
  logic [XLEN-1:0]  wd3_p1;
  wb_src_e          src_p1;

  // Stage 0: M-result buffering and arbitration
  assign bus.MD_READY = !RST && !md_full;
  assign md_push      = bus.MD_VALID && bus.MD_READY;
  assign alu_grant    = bus.ALU_VALID && (bus.ALU_RD != '0);
  assign md_pop       = !RST && !alu_grant && !md_empty;
  assign head_rd      = head[RW-1 -: INDEX];
  assign head_data    = head[XLEN-1:0];
  assign md_grant     = md_pop && (head_rd != '0);
  assign issue_set    = bus.ISSUE_MD && (bus.ISSUE_RD != '0);

  wb_fifo #(
    .DEPTH (MD_DEPTH),
    .WIDTH (RW)
  ) u_md_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (md_push),
    .pop   (md_pop),
    .din   ({bus.MD_RD, bus.MD_DATA}),
    .dout  (head),
    .full  (md_full),
    .empty (md_empty)
  );

  // Stage 1: registered write port; A3/WD3 hold when nothing is granted
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_p1  <= 1'b0;
      a3_p1  <= '0;
      wd3_p1 <= '0;
      src_p1 <= WB_NONE;
    end else if (alu_grant) begin
      we_p1  <= 1'b1;
      a3_p1  <= bus.ALU_RD;
      wd3_p1 <= bus.ALU_DATA;
      src_p1 <= WB_ALU;
    end else if (md_grant) begin
      we_p1  <= 1'b1;
      a3_p1  <= head_rd;
      wd3_p1 <= head_data;
      src_p1 <= WB_MD;
    end else begin
      we_p1  <= 1'b0;
      src_p1 <= WB_NONE;
    end
  end

  assign bus.WE3 = we_p1;
  assign bus.A3  = a3_p1;
  assign bus.WD3 = wd3_p1;

  // Busy bit clears on the edge that writes the M result; a fresh issue to
  // the same register on that edge must win, so the set is applied last.
  always_comb begin
    busy_nxt = busy;
    if (we_p1 && (src_p1 == WB_MD)) busy_nxt[a3_p1] = 1'b0;
    if (issue_set) busy_nxt[bus.ISSUE_RD] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign bus.STALL = busy[bus.RS1] | busy[bus.RS2] | busy[bus.RD_CHK];

`ifdef REGFILE_WB_CHECK_EN
  logic err_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_p1 <= 1'b0;
    end else if ((alu_grant && busy[bus.ALU_RD]) ||
                 (md_grant && !busy[head_rd]) ||
                 (issue_set && busy[bus.ISSUE_RD])) begin
      err_p1 <= 1'b1;
    end
  end

  assign ERR = err_p1;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int XLEN     = 32;
  localparam int INDEX    = 5;
  localparam int MD_DEPTH = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .INDEX(INDEX)) bus ();
`ifdef REGFILE_WB_CHECK_EN
  logic ERR;
`endif

  regfile_wb_arbiter #(
    .XLEN     (XLEN),
    .INDEX    (INDEX),
    .MD_DEPTH (MD_DEPTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef REGFILE_WB_CHECK_EN
    ,
    .ERR (ERR)
`endif
  );

  typedef struct packed {
    logic [INDEX-1:0] rd;
    logic [XLEN-1:0]  data;
  } wr_t;

  typedef struct {
    logic             v;
    logic [INDEX-1:0] rd;
    logic [XLEN-1:0]  d;
    logic             ewe;
    logic [INDEX-1:0] ea3;
    logic [XLEN-1:0]  ewd;
  } alu_vec_t;

  typedef struct {
    logic [INDEX-1:0] rs1;
    logic [INDEX-1:0] rs2;
    logic [INDEX-1:0] rdc;
    logic             estall;
  } stall_vec_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Scoreboard: every register-file write must match the next expected one.
  always @(negedge CLK) begin
    if (bus.WE3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got write a3=%0d wd3=%h want no write", bus.A3, bus.WD3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_a3", 32'(bus.A3), 32'(e.rd));
        chk("sb_wd3", bus.WD3, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ALU_VALID = 1'b0; bus.ALU_RD = '0; bus.ALU_DATA = '0;
    bus.MD_VALID  = 1'b0; bus.MD_RD  = '0; bus.MD_DATA  = '0;
    bus.ISSUE_MD  = 1'b0; bus.ISSUE_RD = '0;
    bus.RS1 = '0; bus.RS2 = '0; bus.RD_CHK = '0;
  endtask

  task automatic issue(input logic [INDEX-1:0] rd);
    idle();
    bus.ISSUE_MD = 1'b1;
    bus.ISSUE_RD = rd;
    tick();
    idle();
  endtask

  task automatic expect_wr(input logic [INDEX-1:0] rd, input logic [XLEN-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  alu_vec_t   av[5];
  stall_vec_t sv[7];

  initial begin
    av[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
    av[1] = '{1'b0, 5'd9,  32'h0000_FFFF, 1'b0, 5'd5,  32'h0000_1234};
    av[2] = '{1'b1, 5'd0,  32'h0000_BEEF, 1'b0, 5'd5,  32'h0000_1234};
    av[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd31, 32'hA5A5_A5A5};
    av[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 5'd1,  32'h0000_0001};

    sv[0] = '{5'd12, 5'd0,  5'd0,  1'b1};
    sv[1] = '{5'd0,  5'd20, 5'd0,  1'b1};
    sv[2] = '{5'd0,  5'd0,  5'd12, 1'b1};
    sv[3] = '{5'd1,  5'd2,  5'd3,  1'b0};
    sv[4] = '{5'd0,  5'd0,  5'd0,  1'b0};
    sv[5] = '{5'd19, 5'd21, 5'd31, 1'b0};
    sv[6] = '{5'd20, 5'd20, 5'd20, 1'b1};

    // Reset with an M result offered
    RST = 1'b1;
    idle();
    bus.MD_VALID = 1'b1;
    bus.MD_RD    = 5'd4;
    bus.MD_DATA  = 32'h4444_4444;
    tick();
    tick();
    chk("rst_we3", 32'(bus.WE3), 32'd0);
    chk("rst_a3", 32'(bus.A3), 32'd0);
    chk("rst_wd3", bus.WD3, 32'd0);
    chk("rst_ready", 32'(bus.MD_READY), 32'd0);
    chk("rst_stall", 32'(bus.STALL), 32'd0);
    RST = 1'b0;
    bus.MD_VALID = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.MD_READY), 32'd1);

    // ALU write-back table
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.ALU_VALID = av[i].v;
      bus.ALU_RD    = av[i].rd;
      bus.ALU_DATA  = av[i].d;
      if (av[i].ewe) expect_wr(av[i].ea3, av[i].ewd);
      tick();
      chk($sformatf("alu_we_%0d", i), 32'(bus.WE3), 32'(av[i].ewe));
      chk($sformatf("alu_a3_%0d", i), 32'(bus.A3), 32'(av[i].ea3));
      chk($sformatf("alu_wd3_%0d", i), bus.WD3, av[i].ewd);
    end
    idle();
    tick();
    chk("alu_we_drop", 32'(bus.WE3), 32'd0);

    // M latency and STALL release
    issue(5'd7);
    bus.RS1 = 5'd7;
    #1;
    chk("md_stall_set", 32'(bus.STALL), 32'd1);
    bus.MD_VALID = 1'b1;
    bus.MD_RD    = 5'd7;
    bus.MD_DATA  = 32'hDEAD_BEEF;
    expect_wr(5'd7, 32'hDEAD_BEEF);
    tick();
    bus.MD_VALID = 1'b0;
    chk("md_n_we", 32'(bus.WE3), 32'd0);
    chk("md_n_stall", 32'(bus.STALL), 32'd1);
    tick();
    chk("md_n1_we", 32'(bus.WE3), 32'd1);
    chk("md_n1_a3", 32'(bus.A3), 32'd7);
    chk("md_n1_wd3", bus.WD3, 32'hDEAD_BEEF);
    chk("md_n1_stall", 32'(bus.STALL), 32'd1);
    tick();
    chk("md_n2_we", 32'(bus.WE3), 32'd0);
    chk("md_n2_stall", 32'(bus.STALL), 32'd0);

    // STALL table against x12/x20 busy
    issue(5'd12);
    issue(5'd20);
    for (int i = 0; i < 7; i++) begin
      bus.RS1 = sv[i].rs1; bus.RS2 = sv[i].rs2; bus.RD_CHK = sv[i].rdc;
      #1;
      chk($sformatf("stall_%0d", i), 32'(bus.STALL), 32'(sv[i].estall));
    end
    idle();
    bus.MD_VALID = 1'b1; bus.MD_RD = 5'd12; bus.MD_DATA = 32'h0000_0C0C;
    expect_wr(5'd12, 32'h0000_0C0C);
    tick();
    bus.MD_RD = 5'd20; bus.MD_DATA = 32'h0000_1414;
    expect_wr(5'd20, 32'h0000_1414);
    tick();
    idle();
    tick(); tick(); tick();
    bus.RS1 = 5'd12; bus.RS2 = 5'd20;
    #1;
    chk("stall_cleared", 32'(bus.STALL), 32'd0);

    // ALU and MD same cycle: ALU first
    issue(5'd9);
    bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'd3; bus.ALU_DATA = 32'h11;
    bus.MD_VALID  = 1'b1; bus.MD_RD  = 5'd9; bus.MD_DATA  = 32'h22;
    expect_wr(5'd3, 32'h11);
    expect_wr(5'd9, 32'h22);
    tick();
    idle();
    chk("prio_a3_first", 32'(bus.A3), 32'd3);
    tick();
    chk("prio_a3_second", 32'(bus.A3), 32'd9);
    chk("prio_wd3_second", bus.WD3, 32'h22);
    tick();
    chk("prio_we_done", 32'(bus.WE3), 32'd0);

    // ALU every cycle fills the FIFO; drain in order afterwards
    issue(5'd10);
    issue(5'd11);
    for (int k = 1; k <= 4; k++) expect_wr(5'(k), 32'h100 + 32'(k));
    expect_wr(5'd10, 32'h0A0A);
    expect_wr(5'd11, 32'h0B0B);
    for (int k = 1; k <= 4; k++) begin
      idle();
      bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'(k); bus.ALU_DATA = 32'h100 + 32'(k);
      if (k == 1) begin bus.MD_VALID = 1'b1; bus.MD_RD = 5'd10; bus.MD_DATA = 32'h0A0A; end
      if (k == 2) begin bus.MD_VALID = 1'b1; bus.MD_RD = 5'd11; bus.MD_DATA = 32'h0B0B; end
      #1;
      chk($sformatf("fill_ready_%0d", k), 32'(bus.MD_READY), (k <= 2) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();
    chk("drain_a3_10", 32'(bus.A3), 32'd10);
    tick();
    chk("drain_a3_11", 32'(bus.A3), 32'd11);
    chk("drain_ready", 32'(bus.MD_READY), 32'd1);
    tick();
    chk("drain_we_done", 32'(bus.WE3), 32'd0);

    // Register 0 everywhere: no write, no stall, FIFO entries discarded
    idle();
    bus.ALU_VALID = 1'b1; bus.ALU_DATA = 32'hFFFF;
    bus.ISSUE_MD  = 1'b1;
    bus.MD_VALID  = 1'b1; bus.MD_DATA = 32'h33;
    #1;
    chk("x0_stall", 32'(bus.STALL), 32'd0);
    tick();
    chk("x0_we_a", 32'(bus.WE3), 32'd0);
    chk("x0_ready_a", 32'(bus.MD_READY), 32'd1);
    tick();
    chk("x0_we_b", 32'(bus.WE3), 32'd0);
    chk("x0_ready_b", 32'(bus.MD_READY), 32'd1);
    idle();
    tick();
    chk("x0_we_c", 32'(bus.WE3), 32'd0);
    chk("x0_stall_c", 32'(bus.STALL), 32'd0);
`ifdef REGFILE_WB_CHECK_EN
    chk("err_clean", 32'(ERR), 32'd0);
`endif

    // Reset mid-operation with a buffered M result
    issue(5'd15);
    bus.RS1 = 5'd15;
    #1;
    chk("mid_stall_pre", 32'(bus.STALL), 32'd1);
    bus.ALU_VALID = 1'b1; bus.ALU_RD = 5'd2;  bus.ALU_DATA = 32'h22;
    bus.MD_VALID  = 1'b1; bus.MD_RD  = 5'd15; bus.MD_DATA  = 32'h55;
    expect_wr(5'd2, 32'h22);
    tick();
    RST = 1'b1;
    idle();
    bus.RS1 = 5'd15;
    #1;
    chk("mid_ready_rst", 32'(bus.MD_READY), 32'd0);
    tick();
    chk("mid_we_rst", 32'(bus.WE3), 32'd0);
    chk("mid_stall_rst", 32'(bus.STALL), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_we_after_%0d", i), 32'(bus.WE3), 32'd0);
    end
    chk("mid_ready_after", 32'(bus.MD_READY), 32'd1);

`ifdef REGFILE_WB_CHECK_EN
    chk("err_after_rst", 32'(ERR), 32'd0);
    issue(5'd6);
    chk("err_first_issue", 32'(ERR), 32'd0);
    issue(5'd6);
    chk("err_double_issue", 32'(ERR), 32'd1);
    tick(); tick();
    chk("err_sticky", 32'(ERR), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("err_cleared", 32'(ERR), 32'd0);
`endif

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
